graycode_decoder: RTL and testbench
===================================

# graycode_decoder

Receive-side companion to the team's Gray-code counter. It samples a WIDTH-bit Gray-coded position bus from another clock domain or an external encoder, converts it to binary, and classifies each change as a step up, a step down, or an illegal jump. It also keeps a wrapping signed position accumulator and a saturating error counter. It sits at the input boundary and feeds position and direction to downstream control logic.

## Interface
- WIDTH, 3: Gray/binary bus width; legal range 2..16.
- POS_W, 8: width of the signed position accumulator.
- ERR_W, 8: width of the saturating error counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- i_gray_code  in  WIDTH  Gray-coded input; may be asynchronous to clk.
- o_bin  out  WIDTH  registered binary equivalent of the last sampled code.
- o_valid  out  1  high from the first post-reset sample onward.
- o_step_up  out  1  one-cycle pulse: binary advanced by +1 (mod 2^WIDTH).
- o_step_dn  out  1  one-cycle pulse: binary moved by −1 (mod 2^WIDTH).
- o_err  out  1  one-cycle pulse: binary changed by any other nonzero amount.
- o_pos  out  POS_W  signed two's-complement step accumulator.
- o_err_cnt  out  ERR_W  count of o_err pulses, saturating at all-ones.

## Operation
- Conversion: bin[WIDTH-1] = g[WIDTH-1]; bin[i] = bin[i+1] ^ g[i] for i below the MSB.
- Each cycle, compute delta = new_bin − o_bin, modulo 2^WIDTH.
- delta = 0: no pulse; o_pos unchanged.
- delta = 1: o_step_up = 1; o_pos += 1.
- delta = 2^WIDTH−1: o_step_dn = 1; o_pos −= 1.
- Any other delta: o_err = 1; o_pos unchanged; o_err_cnt += 1 unless saturated.
- o_bin always takes new_bin, including after an error. The next step is measured from the erroneous value.
- Wrap-around: 7→0 counts as up and 0→7 counts as down (WIDTH=3). For WIDTH=2, a delta of 2 is an error.
- o_pos wraps modulo 2^POS_W and has no saturation.
- First sample after reset (o_valid low):
  - o_bin loads new_bin and o_valid rises.
  - No step or error pulse is generated; o_pos stays 0.
- At most one of o_step_up, o_step_dn, o_err is high in any cycle.
- States: EMPTY (o_valid=0) → TRACK on the first sampled edge. TRACK persists until reset.

## Timing
- Reset values: o_bin=0, o_valid=0, o_step_up=0, o_step_dn=0, o_err=0, o_pos=0, o_err_cnt=0, synchronizer flops=0.
- With GRAY_DEC_SYNC_EN: i_gray_code passes through a 2-flop synchronizer. A change visible before edge n appears on o_bin and the pulses after edge n+2 (latency 3 edges).
- Without GRAY_DEC_SYNC_EN: latency 1 edge.
- o_pos and o_err_cnt update on the same edge as their pulse.
- The input may change every cycle; each sampled value is classified against the previous one independently.
- Reset asserted mid-operation clears everything asynchronously. After release, the first sample is again the silent load.

## Configuration
- GRAY_DEC_SYNC_EN defined: 2-flop synchronizer on i_gray_code; latency 3.
- GRAY_DEC_SYNC_EN undefined: i_gray_code is registered directly by the decode stage; latency 1. Use only when the source is already in the clk domain.

## Structure
- Shared package graycode_pkg:
  - default WIDTH constant;
  - step-class enum {STEP_NONE, STEP_UP, STEP_DN, STEP_ERR};
  - gray-to-binary function, also reusable by the counter side.
- One natural sub-module: gray2bin, a combinational, WIDTH-parameterised converter instantiated in the decode stage.

## Test plan
Latency below assumes the sync build, with each value held 4 cycles.
- Reset, hold 000: o_valid=1 after 3 edges; o_bin=0; no pulses; o_pos=0.
- Feed 001, 011, 010, 110, 111, 101, 100, 000: eight o_step_up pulses; o_bin runs 1..7 then 0; o_pos=8; o_err_cnt=0.
- From 000, feed 100: one o_step_dn pulse; o_bin=7; o_pos=0xFF (−1).
- From 000, feed 011: one o_err pulse and no step; o_bin=2; o_pos unchanged; o_err_cnt=1. Then feed 010: o_step_up; o_bin=3.
- 128 up steps from 0 with POS_W=8: o_pos=0x80. Force 300 errors: o_err_cnt holds at 0xFF.
- Assert reset mid-sequence (o_bin=5): all outputs are 0 immediately. After release, the first sample produces no pulse and o_valid returns high.

Source files
------------

// File: rtl/graycode_pkg.sv
// Shared Gray-code types and helpers for the decoder and the counter side.
package graycode_pkg;

    localparam int GRAY_W = 3;
    localparam int GRAY_MAX_W = 16;

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_UP,
        STEP_DN,
        STEP_ERR
    } step_t;

    typedef enum logic {
        EMPTY,
        TRACK
    } dec_state_t;

    // Zero-extended input keeps bin[msb] = g[msb] for any narrower width.
    function automatic logic [GRAY_MAX_W-1:0] gray_to_bin(
        input logic [GRAY_MAX_W-1:0] g
    );
        logic [GRAY_MAX_W-1:0] b;
        b = g;
        for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/graycode_decoder_if.sv
// Position bus between a Gray-code source, the decoder and its consumers.
interface graycode_decoder_if #(
    parameter int WIDTH = 3,
    parameter int POS_W = 8,
    parameter int ERR_W = 8
);

    logic [WIDTH-1:0] i_gray_code;
    logic [WIDTH-1:0] o_bin;
    logic             o_valid;
    logic             o_step_up;
    logic             o_step_dn;
    logic             o_err;
    logic [POS_W-1:0] o_pos;
    logic [ERR_W-1:0] o_err_cnt;

    modport master (
        output i_gray_code,
        input  o_bin, o_valid, o_step_up, o_step_dn,
        input  o_err, o_pos, o_err_cnt
    );

    modport slave (
        input  i_gray_code,
        output o_bin, o_valid, o_step_up, o_step_dn,
        output o_err, o_pos, o_err_cnt
    );

endinterface

// File: rtl/graycode_decoder_gray2bin.sv
// Combinational WIDTH-bit Gray to binary converter.
module gray2bin
    import graycode_pkg::*;
#(
    parameter int WIDTH = GRAY_W
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    logic [GRAY_MAX_W-1:0] full;

    assign full = gray_to_bin(GRAY_MAX_W'(gray));
    assign bin  = full[WIDTH-1:0];

endmodule

// File: rtl/graycode_decoder.sv
// Gray-code position decoder: step/error classification, position, errors.
// Optional input synchronizer enabled by defining GRAY_DEC_SYNC_EN.
module graycode_decoder
    import graycode_pkg::*;
#(
    parameter int WIDTH = GRAY_W,
    parameter int POS_W = 8,
    parameter int ERR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    graycode_decoder_if.slave bus
);

    logic [WIDTH-1:0] samp;
    logic             samp_vld;
    logic [WIDTH-1:0] new_bin;
    logic [WIDTH-1:0] delta;
    step_t            cls;

    dec_state_t       state_q;
    logic [WIDTH-1:0] bin_q;
    logic             valid_q;
    logic             up_q;
    logic             dn_q;
    logic             err_q;
    logic [POS_W-1:0] pos_q;
    logic [ERR_W-1:0] cnt_q;

`ifdef GRAY_DEC_SYNC_EN
    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic             sv1;
    logic             sv2;

    // Valid bits ride along so reset-value zeros are never decoded.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1 <= '0;
            sync2 <= '0;
            sv1   <= 1'b0;
            sv2   <= 1'b0;
        end else begin
            sync1 <= bus.i_gray_code;
            sync2 <= sync1;
            sv1   <= 1'b1;
            sv2   <= sv1;
        end
    end

    assign samp     = sync2;
    assign samp_vld = sv2;
`else
    assign samp     = bus.i_gray_code;
    assign samp_vld = 1'b1;
`endif

    gray2bin #(
        .WIDTH(WIDTH)
    ) u_gray2bin (
        .gray(samp),
        .bin (new_bin)
    );

    assign delta = new_bin - bin_q;

    always_comb begin
        cls = STEP_NONE;
        if (state_q == TRACK) begin
            if (delta == WIDTH'(1)) begin
                cls = STEP_UP;
            end else if (delta == '1) begin
                cls = STEP_DN;
            end else if (delta != '0) begin
                cls = STEP_ERR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= EMPTY;
            bin_q   <= '0;
            valid_q <= 1'b0;
            up_q    <= 1'b0;
            dn_q    <= 1'b0;
            err_q   <= 1'b0;
            pos_q   <= '0;
            cnt_q   <= '0;
        end else begin
            up_q  <= 1'b0;
            dn_q  <= 1'b0;
            err_q <= 1'b0;
            case (state_q)
                EMPTY: begin
                    if (samp_vld) begin
                        bin_q   <= new_bin;
                        valid_q <= 1'b1;
                        state_q <= TRACK;
                    end
                end
                TRACK: begin
                    bin_q <= new_bin;
                    case (cls)
                        STEP_UP: begin
                            up_q  <= 1'b1;
                            pos_q <= pos_q + POS_W'(1);
                        end
                        STEP_DN: begin
                            dn_q  <= 1'b1;
                            pos_q <= pos_q - POS_W'(1);
                        end
                        STEP_ERR: begin
                            err_q <= 1'b1;
                            if (cnt_q != '1) begin
                                cnt_q <= cnt_q + ERR_W'(1);
                            end
                        end
                        default: ;
                    endcase
                end
                default: state_q <= EMPTY;
            endcase
        end
    end

    assign bus.o_bin     = bin_q;
    assign bus.o_valid   = valid_q;
    assign bus.o_step_up = up_q;
    assign bus.o_step_dn = dn_q;
    assign bus.o_err     = err_q;
    assign bus.o_pos     = pos_q;
    assign bus.o_err_cnt = cnt_q;

endmodule

// File: tb/tb_graycode_decoder.sv
// Randomised and directed bench for graycode_decoder against a position model.
module tb_graycode_decoder;

    localparam int W = 3;
    localparam int M = 1 << W;
`ifdef GRAY_DEC_SYNC_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;

    graycode_decoder_if #(.WIDTH(W), .POS_W(8), .ERR_W(8)) bus ();

    graycode_decoder #(
        .WIDTH(W),
        .POS_W(8),
        .ERR_W(8)
    ) dut (
        .clk  (clk),
        .reset(rst),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    int pipe[$];
    int m_valid, m_bin, m_up, m_dn, m_err, m_pos, m_cnt;
    int cur_b;

    function automatic int enc(input int b);
        return (b ^ (b >> 1)) & (M - 1);
    endfunction

    // Reference decode by exhaustive search over the encoding.
    function automatic int dec(input int g);
        for (int b = 0; b < M; b++) begin
            if (enc(b) == g) return b;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input int got, input int exp);
        n_vec++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pipe.delete();
        for (int i = 0; i < DEPTH; i++) pipe.push_back(-1);
        m_valid = 0; m_bin = 0; m_pos = 0; m_cnt = 0;
        m_up = 0; m_dn = 0; m_err = 0;
    endtask

    task automatic chk_all(input string tag);
        chk({tag, ".bin"}, int'(bus.o_bin), m_bin);
        chk({tag, ".valid"}, int'(bus.o_valid), m_valid);
        chk({tag, ".up"}, int'(bus.o_step_up), m_up);
        chk({tag, ".dn"}, int'(bus.o_step_dn), m_dn);
        chk({tag, ".err"}, int'(bus.o_err), m_err);
        chk({tag, ".pos"}, int'(bus.o_pos), m_pos);
        chk({tag, ".cnt"}, int'(bus.o_err_cnt), m_cnt);
    endtask

    task automatic tick(input int g, input string tag);
        int s, nb, d;
        bus.i_gray_code = W'(g);
        @(posedge clk);
        #1;
        pipe.push_back(g);
        s = pipe.pop_front();
        m_up = 0; m_dn = 0; m_err = 0;
        if (s >= 0) begin
            nb = dec(s);
            if (m_valid == 0) begin
                m_valid = 1;
            end else begin
                d = (nb - m_bin + M) % M;
                if (d == 1) begin
                    m_up = 1; m_pos = (m_pos + 1) % 256;
                end else if (d == M - 1) begin
                    m_dn = 1; m_pos = (m_pos + 255) % 256;
                end else if (d != 0) begin
                    m_err = 1;
                    if (m_cnt < 255) m_cnt++;
                end
            end
            m_bin = nb;
        end
        chk_all(tag);
    endtask

    task automatic hold_bin(input int b, input string tag);
        cur_b = b;
        for (int i = 0; i < 4; i++) tick(enc(b), tag);
    endtask

    initial begin
        int seq[8];
        int r;
        seq = '{1, 2, 3, 4, 5, 6, 7, 0};
        model_reset();
        bus.i_gray_code = '0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_all("reset");
        rst = 1'b0;

        hold_bin(0, "hold0");
        chk("hold0.valid_const", int'(bus.o_valid), 1);

        foreach (seq[i]) hold_bin(seq[i], "upseq");
        chk("upseq.pos8", int'(bus.o_pos), 8);
        chk("upseq.bin0", int'(bus.o_bin), 0);
        chk("upseq.cnt0", int'(bus.o_err_cnt), 0);

        hold_bin(7, "down");
        chk("down.bin7", int'(bus.o_bin), 7);
        chk("down.pos7", int'(bus.o_pos), 7);

        hold_bin(0, "back0");
        hold_bin(2, "jump");
        chk("jump.bin2", int'(bus.o_bin), 2);
        chk("jump.cnt1", int'(bus.o_err_cnt), 1);
        chk("jump.pos8", int'(bus.o_pos), 8);
        hold_bin(3, "afterjump");
        chk("afterjump.bin3", int'(bus.o_bin), 3);

        for (int i = 0; i < 128; i++) begin
            cur_b = (cur_b + 1) % M;
            tick(enc(cur_b), "run128");
        end
        hold_bin(cur_b, "run128h");
        chk("run128.pos", int'(bus.o_pos), (9 + 128) % 256);

        for (int i = 0; i < 300; i++) begin
            cur_b = (cur_b + 4) % M;
            tick(enc(cur_b), "errs");
        end
        hold_bin(cur_b, "errsh");
        chk("errs.sat", int'(bus.o_err_cnt), 255);

        for (int i = 0; i < 400; i++) begin
            r = $urandom_range(0, 3);
            if (r == 0) cur_b = (cur_b + 1) % M;
            else if (r == 1) cur_b = (cur_b + M - 1) % M;
            else if (r == 2) cur_b = $urandom_range(0, M - 1);
            tick(enc(cur_b), "rand");
        end

        hold_bin(5, "pre_rst");
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        chk_all("async_rst");
        @(posedge clk);
        #1;
        chk_all("in_rst");
        rst = 1'b0;
        hold_bin(5, "post_rst");
        chk("post_rst.valid", int'(bus.o_valid), 1);
        chk("post_rst.pos", int'(bus.o_pos), 0);
        hold_bin(6, "post_rst_up");
        chk("post_rst_up.pos", int'(bus.o_pos), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
